pipelined_mult_acc: RTL and testbench

//   Parametrised multiplier with selectable pipeline depth, per-sample signed/unsigned mode
//     and an optional accumulate path.

---
 rtl/dsp_mult_pkg.sv | 23 ++
 rtl/pipe_vld_reg.sv | 25 ++
 rtl/pipelined_mult_acc.sv | 124 ++++++++++++
 tb/tb_pipelined_mult_acc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mult_pkg.sv
// Shared constants and the operand extension helper for the pipelined multiply-accumulate block.
// Extension works on a fixed wide vector; callers truncate the result to the width they need.
package dsp_mult_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;
  localparam int EXT_MAX    = 128;
  localparam int EXT_IDX    = $clog2(EXT_MAX);

  // Keeps the low 'width' bits of value and fills above them with the sign bit (tc=1) or zeros.
  function automatic logic [EXT_MAX-1:0] sext_zext(input logic [EXT_MAX-1:0] value,
                                                   input logic               tc,
                                                   input int                 width);
    logic [EXT_MAX-1:0] mask;
    logic [EXT_IDX-1:0] msb;
    logic               fill;
    mask = (width >= EXT_MAX) ? '1 : ((EXT_MAX'(1) << width) - EXT_MAX'(1));
    msb  = EXT_IDX'(width - 1);
    fill = tc & value[msb];
    return (value & mask) | ({EXT_MAX{fill}} & ~mask);
  endfunction

endpackage

// File: rtl/pipe_vld_reg.sv
// One pipeline stage: data plus valid, loaded when the pipe advances, held otherwise.
// Latency 1 cycle; on a stall (advance=0) both valid and data keep their value.
module pipe_vld_reg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         advance,
  input  logic         d_vld,
  input  logic [W-1:0] d_dat,
  output logic         q_vld,
  output logic [W-1:0] q_dat
);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_vld <= 1'b0;
      q_dat <= '0;
    end else if (advance) begin
      q_vld <= d_vld;
      if (d_vld) q_dat <= d_dat;
    end
  end

endmodule

// File: rtl/pipelined_mult_acc.sv
// Multiplier with NUM_STAGES (2..4) cycles of latency, per-sample signed/unsigned mode and a MAC path.
// Whole pipe stalls together when the output is valid and not taken; in_ready follows out_ready.
module pipelined_mult_acc
  import dsp_mult_pkg::*;
#(
  parameter int A_width    = 16,
  parameter int B_width    = 16,
  parameter int NUM_STAGES = 2,
  parameter int ACC_width  = 40
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_width-1:0]         A,
  input  logic [B_width-1:0]         B,
  input  logic                       TC,
  input  logic                       acc_en,
  input  logic                       acc_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_width+B_width-1:0] PRODUCT,
  output logic [ACC_width-1:0]       ACC
);

  localparam int PW = A_width + B_width;
  localparam int BL = B_width / 2;
  localparam int SW = 2 * PW + 3;

  if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("pipelined_mult_acc: NUM_STAGES=%0d outside %0d..%0d", NUM_STAGES, MIN_STAGES, MAX_STAGES);
  end
  if (ACC_width < PW || ACC_width > EXT_MAX) begin : g_bad_acc
    $error("pipelined_mult_acc: ACC_width=%0d must be in %0d..%0d", ACC_width, PW, EXT_MAX);
  end

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Operands are extended to the full product width so all arithmetic below is exact modulo 2^PW.
  logic [PW-1:0] a_ext, b_ext, b_lo, b_hi, pp_lo, pp_hi;
  logic [SW-1:0] s1_dat;

  always_comb begin
    a_ext  = PW'(sext_zext(EXT_MAX'(A), TC, A_width));
    b_ext  = PW'(sext_zext(EXT_MAX'(B), TC, B_width));
    b_lo   = {{(PW-BL){1'b0}}, b_ext[BL-1:0]};
    b_hi   = b_ext >> BL;
    pp_lo  = a_ext * b_lo;
    pp_hi  = a_ext * b_hi;
    s1_dat = {pp_hi, pp_lo, TC, acc_en, acc_clr};
  end

  logic [SW-1:0]           st_dat [NUM_STAGES-1];
  logic [NUM_STAGES-2:0]   st_vld;

  pipe_vld_reg #(.W(SW)) u_stage1 (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .advance (advance),
    .d_vld   (in_valid),
    .d_dat   (s1_dat),
    .q_vld   (st_vld[0]),
    .q_dat   (st_dat[0])
  );

  for (genvar g = 1; g < NUM_STAGES - 1; g++) begin : g_bal
    pipe_vld_reg #(.W(SW)) u_bal (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .advance (advance),
      .d_vld   (st_vld[g-1]),
      .d_dat   (st_dat[g-1]),
      .q_vld   (st_vld[g]),
      .q_dat   (st_dat[g])
    );
  end

  logic [SW-1:0]        lst_dat;
  logic                 lst_vld;
  logic [PW-1:0]        l_pp_hi, l_pp_lo, product;
  logic                 l_tc, l_en, l_clr;
  logic [ACC_width-1:0] acc_q, p_acc, acc_new, acc_view;

  always_comb begin
    lst_dat  = st_dat[NUM_STAGES-2];
    lst_vld  = st_vld[NUM_STAGES-2];
    l_pp_hi  = lst_dat[SW-1 -: PW];
    l_pp_lo  = lst_dat[PW+2 -: PW];
    l_tc     = lst_dat[2];
    l_en     = lst_dat[1];
    l_clr    = lst_dat[0];
    product  = l_pp_lo + (l_pp_hi << BL);
    p_acc    = ACC_width'(sext_zext(EXT_MAX'(product), l_tc, PW));
    acc_new  = l_clr ? p_acc : acc_q + p_acc;
    acc_view = l_en ? acc_new : p_acc;
  end

  // Only samples that actually leave the last balance stage may touch the accumulator.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc_q <= '0;
    end else if (advance && lst_vld && l_en) begin
      acc_q <= acc_new;
    end
  end

  logic [PW+ACC_width-1:0] out_dat;

  pipe_vld_reg #(.W(PW+ACC_width)) u_out (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .advance (advance),
    .d_vld   (lst_vld),
    .d_dat   ({product, acc_view}),
    .q_vld   (out_valid),
    .q_dat   (out_dat)
  );

  assign PRODUCT = out_dat[ACC_width +: PW];
  assign ACC     = out_dat[ACC_width-1:0];

endmodule

// File: tb/tb_pipelined_mult_acc.sv
// Bench for pipelined_mult_acc at NUM_STAGES 2, 3 and 4 side by side, each against a queue-based model.
module tb_pipelined_mult_acc;

  localparam int AW    = 16;
  localparam int BW    = 16;
  localparam int CW    = 40;
  localparam int NRAND = 10000;

  // op: 0 sample, 1 stall output 5 cycles, 2 reset, 3 drain, 4 random out_ready, 5 idle cycle
  typedef struct {
    logic [15:0] a, b;
    bit          tc, en, clr;
    int          op;
    bit          lit;
    logic [31:0] lp;
    logic [39:0] la;
  } stim_t;

  typedef struct {
    logic [31:0] prod;
    logic [39:0] acc;
    int          idx;
    bit          lit;
    logic [31:0] lp;
    logic [39:0] la;
  } item_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int    n_cmp = 0;
  int    n_bad = 0;
  stim_t dir[$];

  task automatic chk(input int ns, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL ns=%0d %s: got %h expected %h at %0t", ns, name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [15:0] a, input logic [15:0] b, input bit tc, input bit en,
                               input bit clr, input int op, input bit lit, input logic [31:0] lp,
                               input logic [39:0] la);
    stim_t s;
    s.a = a; s.b = b; s.tc = tc; s.en = en; s.clr = clr;
    s.op = op; s.lit = lit; s.lp = lp; s.la = la;
    return s;
  endfunction

  initial begin
    dir.push_back(mk(16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 1, 32'hFFFE0001, 40'h00FFFE0001));
    dir.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0));
    dir.push_back(mk(16'hFFFF, 16'h8000, 1, 0, 0, 0, 1, 32'h00008000, 40'h0000008000));
    dir.push_back(mk(16'hFFFF, 16'h8000, 0, 0, 0, 0, 1, 32'h7FFF8000, 40'h007FFF8000));
    dir.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0));
    dir.push_back(mk(16'd3, 16'd4, 1, 1, 1, 0, 1, 32'h0000000C, 40'd12));
    dir.push_back(mk(16'hFFFE, 16'd5, 1, 1, 0, 0, 1, 32'hFFFFFFF6, 40'd2));
    dir.push_back(mk(16'd7, 16'hFFFF, 1, 1, 0, 0, 1, 32'hFFFFFFF9, 40'hFFFFFFFFFB));
    dir.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      dir.push_back(mk(16'(i * 4099 + 17), 16'(i * 7919 + 3), i[0], 0, 0, 0, 0, 0, 0));
      if (i == 2) dir.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    end
    dir.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0));
    for (int i = 0; i < 3; i++) dir.push_back(mk(16'(i + 5), 16'(i + 9), 1, 1, 0, 0, 0, 0, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0));
    dir.push_back(mk(16'd2, 16'd2, 1, 1, 0, 0, 1, 32'd4, 40'd4));
    dir.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0));
  end

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int NS = g + 2;

    logic        rst_n = 1'b0, in_valid = 1'b0, tc = 1'b0, acc_en = 1'b0, acc_clr = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [15:0] a = '0, b = '0;
    logic [31:0] product;
    logic [39:0] acc;
    bit          lit = 1'b0;
    logic [31:0] lp = '0;
    logic [39:0] la = '0;
    int          stall = 0;
    bit          rnd = 1'b0;
    bit          fin = 1'b0;
    item_t       q[$];

    pipelined_mult_acc #(.A_width(AW), .B_width(BW), .NUM_STAGES(NS), .ACC_width(CW)) dut (
      .CLK(CLK), .RST_N(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .TC(tc), .acc_en(acc_en), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .PRODUCT(product), .ACC(acc)
    );

    initial begin
      forever begin
        @(posedge CLK);
        #2;
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
    end

    initial begin
      stim_t s[$];
      stim_t r;
      int    w;
      bit    ok;
      foreach (dir[i]) s.push_back(dir[i]);
      s.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 0));
      for (int i = 0; i < NRAND; i++) begin
        if ($urandom_range(0, 3) == 0) s.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 0));
        r = mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0);
        if ($urandom_range(0, 7) == 0) r.a = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'hFFFF;
        if ($urandom_range(0, 7) == 0) r.b = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h0000;
        r.clr = r.en && ($urandom_range(0, 7) == 0);
        s.push_back(r);
      end
      s.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0));

      repeat (3) @(posedge CLK);
      #1 rst_n = 1'b1;
      foreach (s[i]) begin
        case (s[i].op)
          0: begin
            a = s[i].a; b = s[i].b; tc = s[i].tc; acc_en = s[i].en; acc_clr = s[i].clr;
            lit = s[i].lit; lp = s[i].lp; la = s[i].la;
            in_valid = 1'b1;
            w = 0;
            ok = 1'b0;
            do begin
              @(negedge CLK);
              ok = in_ready;
              w++;
            end while (!ok && w < 300);
            if (!ok) chk(NS, "accept_timeout", 64'(in_ready), 64'(1));
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
            lit = 1'b0;
          end
          1: stall = 5;
          2: begin
            rst_n = 1'b0;
            repeat (2) @(posedge CLK);
            #1 rst_n = 1'b1;
          end
          3: begin
            w = 0;
            while (q.size() > 0 && w < 200) begin
              @(posedge CLK);
              w++;
            end
            if (w > 0) #1;
            chk(NS, "drained", 64'(q.size()), 64'(0));
          end
          4: rnd = 1'b1;
          5: begin
            @(posedge CLK);
            #1;
          end
          default: ;
        endcase
      end
      fin = 1'b1;
    end

    initial begin
      logic [39:0] macc, p40;
      longint      fa, fb, full;
      item_t       it;
      int          adv;
      bit          rp, alive, exp_v;
      macc = '0; adv = 0; rp = 1'b0; alive = 1'b0;
      forever begin
        @(negedge CLK);
        if (rp) begin
          alive = 1'b1;
          chk(NS, "rst_out_valid", 64'(out_valid), 64'(0));
          chk(NS, "rst_product", 64'(product), 64'(0));
          chk(NS, "rst_acc", 64'(acc), 64'(0));
          chk(NS, "rst_in_ready", 64'(in_ready), 64'(1));
        end else if (alive) begin
          exp_v = (q.size() > 0) && (adv >= q[0].idx + NS);
          chk(NS, "out_valid", 64'(out_valid), 64'(exp_v));
          if (exp_v && out_valid) begin
            chk(NS, "product", 64'(product), 64'(q[0].prod));
            chk(NS, "acc", 64'(acc), 64'(q[0].acc));
            if (q[0].lit) begin
              chk(NS, "product_lit", 64'(product), 64'(q[0].lp));
              chk(NS, "acc_lit", 64'(acc), 64'(q[0].la));
            end
          end
          chk(NS, "in_ready", 64'(in_ready), 64'(out_ready || !out_valid));
        end
        if (alive && rst_n) begin
          if (in_valid && in_ready) begin
            fa   = tc ? longint'($signed(a)) : longint'(a);
            fb   = tc ? longint'($signed(b)) : longint'(b);
            full = fa * fb;
            p40  = full[39:0];
            it.prod = full[31:0];
            if (acc_en) begin
              macc   = acc_clr ? p40 : macc + p40;
              it.acc = macc;
            end else begin
              it.acc = p40;
            end
            it.idx = adv;
            it.lit = lit; it.lp = lp; it.la = la;
            q.push_back(it);
          end
          if (out_valid && out_ready && q.size() > 0 && adv >= q[0].idx + NS) void'(q.pop_front());
          if (in_ready) adv++;
        end
        if (!rst_n) begin
          q.delete();
          macc = '0;
          rp = 1'b1;
        end else begin
          rp = 1'b0;
        end
      end
    end
  end

  initial begin
    int cyc;
    bit all_done;
    cyc = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 90000) begin
      @(posedge CLK);
      cyc++;
      all_done = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
    end
    chk(0, "run_complete", 64'(all_done), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
